// File: rtl/am4_qbus_slave_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | am4_qbus_slave_pkg                                                   |
// | State encodings, Qbus cycle types and byte-enable helper.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package am4_qbus_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEL     = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_RPLY = 3'd3,
    ST_WR_REQ  = 3'd4,
    ST_WR_RPLY = 3'd5,
    ST_SKIP    = 3'd6
  } state_t;

  localparam logic [1:0] C_CYC_DATI  = 2'd0;
  localparam logic [1:0] C_CYC_DATO  = 2'd1;
  localparam logic [1:0] C_CYC_DATIO = 2'd2;

  // Byte writes select the lane from address bit 0; word writes use both.
  function automatic logic [1:0] byte_en(input logic wtbt, input logic a0);
    if (!wtbt)
      return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/am4_qbus_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | am4_qbus_slave_if                                                    |
// | Qbus pin group plus local register bus, with master/slave views.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface am4_qbus_slave_if #(
  parameter int ADDR_BITS = 5
);
  logic                 pin_init;
  logic                 pin_sync;
  logic                 pin_din;
  logic                 pin_dout;
  logic                 pin_wtbt;
  logic                 pin_bs7;
  logic [15:0]          pin_ad_in;
  logic [15:0]          pin_ad_out;
  logic                 pin_ad_ena;
  logic                 pin_rply;
  logic                 loc_req;
  logic                 loc_wr;
  logic [1:0]           loc_be;
  logic [ADDR_BITS-2:0] loc_addr;
  logic [15:0]          loc_wdata;
  logic [15:0]          loc_rdata;
  logic                 loc_ack;

  modport slave (
    input  pin_init, pin_sync, pin_din, pin_dout, pin_wtbt, pin_bs7, pin_ad_in,
    output pin_ad_out, pin_ad_ena, pin_rply,
    output loc_req, loc_wr, loc_be, loc_addr, loc_wdata,
    input  loc_rdata, loc_ack
  );

  modport master (
    output pin_init, pin_sync, pin_din, pin_dout, pin_wtbt, pin_bs7, pin_ad_in,
    input  pin_ad_out, pin_ad_ena, pin_rply,
    input  loc_req, loc_wr, loc_be, loc_addr, loc_wdata,
    output loc_rdata, loc_ack
  );
endinterface
`default_nettype wire

// File: rtl/am4_qbus_slave_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | am4_sync2                                                            |
// | Parameterised-width 2-flop synchronizer, both stages visible.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module am4_sync2 #(
  parameter int WIDTH = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q1,
  output logic      [WIDTH-1:0] o_q2
);
  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q1 = r_q1;
  assign o_q2 = r_q2;
endmodule
`default_nettype wire

// File: rtl/am4_qbus_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | am4_qbus_slave                                                       |
// | Qbus target port bridging DATI/DATO(B)/DATIO(B) to a req/ack bus.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module am4_qbus_slave
  import am4_qbus_slave_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'o177000,
  parameter int          ADDR_BITS = 5,
  parameter bit          IOPAGE    = 1'b1,
  parameter int          LOC_TMO   = 15
) (
  input wire logic         pin_clk,
  input wire logic         pin_dclo_n,
  am4_qbus_slave_if.slave  bus
);
  logic [3:0]           w_s1;
  logic [3:0]           w_s2;
  logic                 w_init_s2, w_sync_s2, w_din_s2, w_dout_s2;
  logic                 w_addr_phase, w_sel;

  state_t               r_state;
  logic [15:0]          r_addr;
  logic                 r_bs7;
  logic [7:0]           r_tmo;
  logic [15:0]          r_ad_out;
  logic                 r_ad_ena, r_rply, r_loc_req, r_loc_wr;
  logic [1:0]           r_loc_be;
  logic [ADDR_BITS-2:0] r_loc_addr;
  logic [15:0]          r_loc_wdata;

  am4_sync2 #(.WIDTH(4)) u_sync (
    .clk   (pin_clk),
    .rst_n (pin_dclo_n),
    .i_d   ({bus.pin_init, bus.pin_sync, bus.pin_din, bus.pin_dout}),
    .o_q1  (w_s1),
    .o_q2  (w_s2)
  );

  assign w_init_s2 = w_s2[3];
  assign w_sync_s2 = w_s2[2];
  assign w_din_s2  = w_s2[1];
  assign w_dout_s2 = w_s2[0];

  // AD carries the address only while SYNC is up alone, ahead of any strobe.
  assign w_addr_phase = (w_s1 == 4'b0100) && !w_sync_s2;
  assign w_sel = (r_addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]) && (r_bs7 || !IOPAGE);

  always_ff @(posedge pin_clk) begin
    if (!pin_dclo_n || w_init_s2) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_bs7       <= 1'b0;
      r_tmo       <= '0;
      r_ad_out    <= '0;
      r_ad_ena    <= 1'b0;
      r_rply      <= 1'b0;
      r_loc_req   <= 1'b0;
      r_loc_wr    <= 1'b0;
      r_loc_be    <= '0;
      r_loc_addr  <= '0;
      r_loc_wdata <= '0;
    end else if (!w_sync_s2 && r_state != ST_IDLE &&
                 r_state != ST_RD_RPLY && r_state != ST_WR_RPLY) begin
      r_state     <= ST_IDLE;
      r_ad_out    <= '0;
      r_ad_ena    <= 1'b0;
      r_rply      <= 1'b0;
      r_loc_req   <= 1'b0;
      r_loc_wr    <= 1'b0;
      r_loc_be    <= '0;
      r_loc_addr  <= '0;
      r_loc_wdata <= '0;
    end else begin
      if (r_state == ST_IDLE && w_addr_phase) begin
        r_addr <= bus.pin_ad_in;
        r_bs7  <= bus.pin_bs7;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_sync_s2) begin
            if (w_sel) begin
              r_state    <= ST_SEL;
              r_loc_addr <= r_addr[ADDR_BITS-1:1];
            end else begin
              r_state <= ST_SKIP;
            end
          end
        end
        ST_SEL: begin
          if (w_din_s2) begin
            r_state   <= ST_RD_REQ;
            r_loc_req <= 1'b1;
            r_loc_wr  <= 1'b0;
            r_loc_be  <= 2'b11;
            r_tmo     <= 8'(LOC_TMO);
          end else if (w_dout_s2) begin
            r_state     <= ST_WR_REQ;
            r_loc_req   <= 1'b1;
            r_loc_wr    <= 1'b1;
            r_loc_be    <= byte_en(bus.pin_wtbt, r_addr[0]);
            r_loc_wdata <= bus.pin_ad_in;
            r_tmo       <= 8'(LOC_TMO);
          end
        end
        ST_RD_REQ, ST_WR_REQ: begin
          if (bus.loc_ack) begin
            r_loc_req <= 1'b0;
            r_rply    <= 1'b1;
            if (r_state == ST_RD_REQ) begin
              r_state  <= ST_RD_RPLY;
              r_ad_out <= bus.loc_rdata;
              r_ad_ena <= 1'b1;
            end else begin
              r_state <= ST_WR_RPLY;
            end
          end else if (r_tmo <= 8'd1) begin
            // No RPLY: the master's own bus timeout takes over.
            r_state   <= ST_SKIP;
            r_loc_req <= 1'b0;
            r_loc_wr  <= 1'b0;
            r_loc_be  <= '0;
          end else begin
            r_tmo <= r_tmo - 8'd1;
          end
        end
        ST_RD_RPLY: begin
          if (!w_din_s2) begin
            r_state  <= ST_SEL;
            r_rply   <= 1'b0;
            r_ad_ena <= 1'b0;
            r_ad_out <= '0;
          end
        end
        ST_WR_RPLY: begin
          if (!w_dout_s2) begin
            r_state <= ST_SEL;
            r_rply  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pin_ad_out = r_ad_out;
  assign bus.pin_ad_ena = r_ad_ena;
  assign bus.pin_rply   = r_rply;
  assign bus.loc_req    = r_loc_req;
  assign bus.loc_wr     = r_loc_wr;
  assign bus.loc_be     = r_loc_be;
  assign bus.loc_addr   = r_loc_addr;
  assign bus.loc_wdata  = r_loc_wdata;
endmodule
`default_nettype wire

// File: tb/tb_am4_qbus_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_am4_qbus_slave                                                    |
// | Directed Qbus cycles against the am4_qbus_slave target port.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_am4_qbus_slave;
  import am4_qbus_slave_pkg::*;

  logic pin_clk    = 1'b0;
  logic pin_dclo_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  am4_qbus_slave_if #(.ADDR_BITS(5)) bus();

  am4_qbus_slave #(
    .BASE_ADDR (16'o177000),
    .ADDR_BITS (5),
    .IOPAGE    (1'b1),
    .LOC_TMO   (15)
  ) dut (
    .pin_clk    (pin_clk),
    .pin_dclo_n (pin_dclo_n),
    .bus        (bus)
  );

  always #5 pin_clk = ~pin_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge pin_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
      end
  endtask

  task automatic addr_phase(input logic [15:0] a, input logic bs7);
    bus.pin_ad_in = a;
    bus.pin_bs7   = bs7;
    bus.pin_sync  = 1'b1;
    tick(3);
  endtask

  task automatic end_sync();
    bus.pin_sync = 1'b0;
    tick(3);
  endtask

  task automatic ack_pulse(input logic [15:0] rd);
    bus.loc_rdata = rd;
    bus.loc_ack   = 1'b1;
    tick(1);
    bus.loc_ack   = 1'b0;
  endtask

  initial begin
    bus.pin_init = 0; bus.pin_sync = 0; bus.pin_din = 0; bus.pin_dout = 0;
    bus.pin_wtbt = 0; bus.pin_bs7 = 0; bus.pin_ad_in = 0;
    bus.loc_rdata = 0; bus.loc_ack = 0;

    // Reset state
    tick(3);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("rst_rply", 32'(bus.pin_rply), 0);
    chk("rst_ad_ena", 32'(bus.pin_ad_ena), 0);
    chk("rst_ad_out", 32'(bus.pin_ad_out), 0);
    chk("rst_req", 32'(bus.loc_req), 0);
    chk("rst_wr", 32'(bus.loc_wr), 0);
    chk("rst_be", 32'(bus.loc_be), 0);
    chk("rst_addr", 32'(bus.loc_addr), 0);
    chk("rst_wdata", 32'(bus.loc_wdata), 0);
    pin_dclo_n = 1'b1;
    tick(1);

    // Stray ack in IDLE
    ack_pulse(16'o777);
    tick(1);
    chk("stray_req", 32'(bus.loc_req), 0);
    chk("stray_rply", 32'(bus.pin_rply), 0);

    // DATI 177004
    addr_phase(16'o177004, 1'b1);
    chk("dati_sel", 32'(dut.r_state), 32'(ST_SEL));
    bus.pin_ad_in = 16'o0;
    bus.pin_din = 1'b1;
    tick(2);
    chk("dati_req_early", 32'(bus.loc_req), 0);
    tick(1);
    chk("dati_req", 32'(bus.loc_req), 1);
    chk("dati_wr", 32'(bus.loc_wr), 0);
    chk("dati_be", 32'(bus.loc_be), 2'b11);
    chk("dati_addr", 32'(bus.loc_addr), 2);
    tick(2);
    chk("dati_req_hold", 32'(bus.loc_req), 1);
    ack_pulse(16'o123456);
    chk("dati_rply", 32'(bus.pin_rply), 1);
    chk("dati_ena", 32'(bus.pin_ad_ena), 1);
    chk("dati_data", 32'(bus.pin_ad_out), 32'o123456);
    chk("dati_req_off", 32'(bus.loc_req), 0);
    bus.pin_din = 1'b0;
    tick(2);
    chk("dati_rply_hold", 32'(bus.pin_rply), 1);
    tick(1);
    chk("dati_rply_rel", 32'(bus.pin_rply), 0);
    chk("dati_ena_rel", 32'(bus.pin_ad_ena), 0);
    end_sync();
    chk("dati_idle", 32'(dut.r_state), 32'(ST_IDLE));

    // DATOB 177011, high byte
    addr_phase(16'o177011, 1'b1);
    bus.pin_ad_in = 16'o000377;
    bus.pin_wtbt  = 1'b1;
    bus.pin_dout  = 1'b1;
    tick(3);
    chk("datob_req", 32'(bus.loc_req), 1);
    chk("datob_wr", 32'(bus.loc_wr), 1);
    chk("datob_be", 32'(bus.loc_be), 2'b10);
    chk("datob_addr", 32'(bus.loc_addr), 4);
    chk("datob_wdata", 32'(bus.loc_wdata), 32'o000377);
    ack_pulse(16'o0);
    chk("datob_rply", 32'(bus.pin_rply), 1);
    chk("datob_ena", 32'(bus.pin_ad_ena), 0);
    bus.pin_dout = 1'b0;
    bus.pin_wtbt = 1'b0;
    tick(3);
    chk("datob_rply_rel", 32'(bus.pin_rply), 0);
    end_sync();

    // DATIO 177002
    addr_phase(16'o177002, 1'b1);
    bus.pin_din = 1'b1;
    tick(3);
    chk("datio_rd_req", 32'(bus.loc_req), 1);
    chk("datio_rd_addr", 32'(bus.loc_addr), 1);
    ack_pulse(16'o000111);
    chk("datio_rd_rply", 32'(bus.pin_rply), 1);
    chk("datio_rd_data", 32'(bus.pin_ad_out), 32'o000111);
    bus.pin_din = 1'b0;
    tick(3);
    chk("datio_rd_rel", 32'(bus.pin_rply), 0);
    bus.pin_ad_in = 16'o052525;
    bus.pin_dout  = 1'b1;
    tick(3);
    chk("datio_wr_req", 32'(bus.loc_req), 1);
    chk("datio_wr_wr", 32'(bus.loc_wr), 1);
    chk("datio_wr_be", 32'(bus.loc_be), 2'b11);
    chk("datio_wr_data", 32'(bus.loc_wdata), 32'o052525);
    ack_pulse(16'o0);
    chk("datio_wr_rply", 32'(bus.pin_rply), 1);
    bus.pin_dout = 1'b0;
    tick(3);
    chk("datio_wr_rel", 32'(bus.pin_rply), 0);
    end_sync();

    // Outside window
    addr_phase(16'o176000, 1'b1);
    chk("miss_skip", 32'(dut.r_state), 32'(ST_SKIP));
    bus.pin_din = 1'b1;
    tick(4);
    chk("miss_req", 32'(bus.loc_req), 0);
    chk("miss_rply", 32'(bus.pin_rply), 0);
    bus.pin_din = 1'b0;
    end_sync();
    chk("miss_idle", 32'(dut.r_state), 32'(ST_IDLE));

    // In window but BS7 low
    addr_phase(16'o177004, 1'b0);
    chk("bs7_skip", 32'(dut.r_state), 32'(ST_SKIP));
    bus.pin_din = 1'b1;
    tick(4);
    chk("bs7_req", 32'(bus.loc_req), 0);
    bus.pin_din = 1'b0;
    end_sync();

    // Local timeout
    addr_phase(16'o177004, 1'b1);
    bus.pin_din = 1'b1;
    tick(3);
    chk("tmo_req", 32'(bus.loc_req), 1);
    tick(14);
    chk("tmo_req_14", 32'(bus.loc_req), 1);
    tick(1);
    chk("tmo_req_15", 32'(bus.loc_req), 0);
    chk("tmo_rply", 32'(bus.pin_rply), 0);
    chk("tmo_skip", 32'(dut.r_state), 32'(ST_SKIP));
    bus.pin_din = 1'b0;
    end_sync();
    chk("tmo_idle", 32'(dut.r_state), 32'(ST_IDLE));

    // INIT during RD_RPLY
    addr_phase(16'o177004, 1'b1);
    bus.pin_din = 1'b1;
    tick(3);
    ack_pulse(16'o070707);
    chk("init_pre_rply", 32'(bus.pin_rply), 1);
    bus.pin_init = 1'b1;
    tick(1);
    bus.pin_init = 1'b0;
    tick(2);
    chk("init_rply", 32'(bus.pin_rply), 0);
    chk("init_ena", 32'(bus.pin_ad_ena), 0);
    chk("init_state", 32'(dut.r_state), 32'(ST_IDLE));
    bus.pin_din = 1'b0;
    bus.pin_sync = 1'b0;
    tick(4);
    chk("init_final", 32'(dut.r_state), 32'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire
